pe_seq_ctrl: RTL and testbench

- Sequences one 7x3 convolution PE through one 3x3-kernel output tile.
- Steps over all input channels and kernel rows: issues IFM/weight buffer reads, drives the PE enable, and accumulates the PE's 9 registered partial sums into 9 accumulators.
- Presents the finished tile on a valid/ready output.
- Sits between the on-chip IFM/weight buffers and the PE, below the layer-level scheduler, which issues start pulses.

---
 rtl/pe_seq_ctrl_pkg.sv | 17 +
 rtl/pe_seq_ctrl_acc_bank.sv | 33 +++
 rtl/pe_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_pe_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_ctrl_pkg.sv
// Shared definitions for the convolution PE tile sequencer: state encoding
// and PE geometry constants.
package pe_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int PE_LANES = 9;
  localparam int PE_IFM   = 7;
  localparam int PE_WHT   = 3;
  localparam int ACC_W    = 32;

endpackage : pe_seq_ctrl_pkg

// File: rtl/pe_seq_ctrl_acc_bank.sv
// Nine-lane wrapping accumulator bank: synchronous clear, add-enable and a
// packed output using the same lane packing as the PE result bus.
module pe_acc_bank #(
  parameter int ACC_W = pe_seq_ctrl_pkg::ACC_W
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clr_i,
  input  logic                                     add_en_i,
  input  logic [pe_seq_ctrl_pkg::PE_LANES*ACC_W-1:0] add_i,
  output logic [pe_seq_ctrl_pkg::PE_LANES*ACC_W-1:0] acc_o
);
  import pe_seq_ctrl_pkg::*;

  logic [PE_LANES-1:0][ACC_W-1:0] acc_q;

  // NOTE: the accumulators are flops, not RAM, so they take the async reset;
  // an aborted tile must never leak partial sums into the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (add_en_i) begin
      for (int j = 0; j < PE_LANES; j++) begin
        acc_q[j] <= acc_q[j] + add_i[j*ACC_W +: ACC_W];
      end
    end
  end

  assign acc_o = acc_q;

endmodule : pe_acc_bank

// File: rtl/pe_seq_ctrl.sv
// Tile sequencer for one 7x3 PE: walks cin*KROWS steps, issues buffer reads,
// pipelines the PE enable and accumulates results, then hands the tile off.
module pe_seq_ctrl #(
  parameter int CIN_W  = 8,
  parameter int ADDR_W = 12,
  parameter int ACC_W  = pe_seq_ctrl_pkg::ACC_W,
  parameter int KROWS  = 3
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [CIN_W-1:0]                           cfg_cin,
  input  logic [ADDR_W-1:0]                          cfg_ifm_base,
  input  logic                                       cfg_type,
  output logic                                       busy,
  output logic                                       ifm_rd_en,
  output logic [ADDR_W-1:0]                          ifm_rd_addr,
  output logic                                       wht_rd_en,
  output logic [ADDR_W-1:0]                          wht_rd_addr,
  output logic                                       pe_en,
  output logic                                       pe_type,
  input  logic [pe_seq_ctrl_pkg::PE_LANES*ACC_W-1:0] pe_res,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [pe_seq_ctrl_pkg::PE_LANES*ACC_W-1:0] acc_o
);
  import pe_seq_ctrl_pkg::*;

  // Wide enough for the largest step count, (2^CIN_W - 1) * KROWS.
  localparam int STEP_W = $clog2(((2**CIN_W) - 1) * KROWS + 1);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   k_q, k_d;
  logic [STEP_W-1:0]   n_q, n_d;
  logic [STEP_W-1:0]   n_start;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                type_q, type_d;
  logic                v1_q, v1_d;
  logic                v2_q;
  logic                acc_clr;
  logic                run_active;

  assign n_start = STEP_W'(cfg_cin) * STEP_W'(KROWS);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    base_d  = base_q;
    type_d  = type_q;
    v1_d    = 1'b0;
    acc_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_start;
          base_d  = cfg_ifm_base;
          type_d  = cfg_type;
          k_d     = '0;
          acc_clr = 1'b1;
          state_d = (n_start != '0) ? RUN : OUT;
        end
      end
      RUN: begin
        v1_d = 1'b1;
        k_d  = k_q + 1'b1;
        if (k_q == n_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        // Stage 2 loads v1_q next, so both stages are empty after this edge
        // exactly when stage 1 is already empty.
        if (!v1_q) state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      type_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      base_q  <= base_d;
      type_q  <= type_d;
      v1_q    <= v1_d;
      v2_q    <= v1_q;
    end
  end

  assign run_active  = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign ifm_rd_en   = run_active;
  assign wht_rd_en   = run_active;
  assign ifm_rd_addr = run_active ? base_q + ADDR_W'(k_q) : '0;
  assign wht_rd_addr = run_active ? ADDR_W'(k_q) : '0;
  assign pe_en       = v1_q;
  assign pe_type     = type_q;
  assign out_valid   = (state_q == OUT);

  pe_acc_bank #(
    .ACC_W (ACC_W)
  ) u_acc_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (acc_clr),
    .add_en_i (v2_q),
    .add_i    (pe_res),
    .acc_o    (acc_o)
  );

endmodule : pe_seq_ctrl

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: directed vector table, backpressure,
// reset-abort sequence and randomized tiles against a summing reference model.
module tb_pe_seq_ctrl;

  localparam int CIN_W  = 8;
  localparam int ADDR_W = 12;
  localparam int ACC_W  = 32;
  localparam int KROWS  = 3;
  localparam int LANES  = 9;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [CIN_W-1:0]       cfg_cin;
  logic [ADDR_W-1:0]      cfg_ifm_base;
  logic                   cfg_type;
  logic                   busy;
  logic                   ifm_rd_en;
  logic [ADDR_W-1:0]      ifm_rd_addr;
  logic                   wht_rd_en;
  logic [ADDR_W-1:0]      wht_rd_addr;
  logic                   pe_en;
  logic                   pe_type;
  logic [LANES*ACC_W-1:0] pe_res;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] acc_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Stub PE behaviour selector and per-tile random salts.
  int          mode = 0;
  logic [31:0] salt [LANES];

  always #5 clk = ~clk;

  pe_seq_ctrl #(
    .CIN_W (CIN_W), .ADDR_W (ADDR_W), .ACC_W (ACC_W), .KROWS (KROWS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_cin      (cfg_cin),
    .cfg_ifm_base (cfg_ifm_base),
    .cfg_type     (cfg_type),
    .busy         (busy),
    .ifm_rd_en    (ifm_rd_en),
    .ifm_rd_addr  (ifm_rd_addr),
    .wht_rd_en    (wht_rd_en),
    .wht_rd_addr  (wht_rd_addr),
    .pe_en        (pe_en),
    .pe_type      (pe_type),
    .pe_res       (pe_res),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .acc_o        (acc_o)
  );

  // Value a PE lane produces for one step, as a function of the IFM address
  // and weight address that fed it.
  function automatic logic [31:0] pe_f(input int md, input logic [11:0] a,
                                       input logic [11:0] w, input int j);
    case (md)
      0: return 32'(j + 1);
      1: return 32'd1;
      2: begin
        if (j == 0) return (w == 12'd0) ? 32'h7FFF_FFFF : (w == 12'd1) ? 32'd1 : 32'd0;
        else if (j == 1) return 32'hFFFF_FFFB;
        else return 32'd0;
      end
      default: return salt[j] * ({20'b0, a} ^ 32'h5A5) + {20'b0, w} * 32'(j + 3);
    endcase
  endfunction

  // Buffers return the addressed word one cycle after the read; the PE
  // registers its result one cycle after pe_en.
  logic [11:0] ifm_q = '0, wht_q = '0;
  initial pe_res = '0;
  always @(posedge clk) begin
    if (ifm_rd_en) ifm_q <= ifm_rd_addr;
    if (wht_rd_en) wht_q <= wht_rd_addr;
    if (pe_en) begin
      for (int j = 0; j < LANES; j++) pe_res[j*ACC_W +: ACC_W] <= pe_f(mode, ifm_q, wht_q, j);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int j);
    return acc_o[j*ACC_W +: ACC_W];
  endfunction

  // Runs one tile and checks timing, reads, PE enables and the result against
  // a model that simply sums the stub PE outputs over all steps.
  task automatic run_tile(input int cin, input int base, input bit tp, input int md,
                          input bit ready_early, input int hold, output int ov_cyc);
    int n, rd_cnt, pe_cnt, pe_first, pe_last, cyc;
    bit addr_ok, type_ok, busy_ok, stable;
    logic [31:0] exp_acc [LANES];
    logic [LANES*ACC_W-1:0] snap;
    n = cin * KROWS;
    for (int j = 0; j < LANES; j++) exp_acc[j] = '0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < LANES; j++) exp_acc[j] += pe_f(md, 12'(base + k), 12'(k), j);
    end
    mode = md;
    @(negedge clk);
    start = 1'b1; cfg_cin = CIN_W'(cin); cfg_ifm_base = ADDR_W'(base); cfg_type = tp;
    out_ready = ready_early;
    @(negedge clk);
    start = 1'b0; cfg_cin = '0; cfg_ifm_base = '0; cfg_type = ~tp;
    cyc = 1; ov_cyc = -1; rd_cnt = 0; pe_cnt = 0; pe_first = -1; pe_last = -1;
    addr_ok = 1'b1; type_ok = 1'b1; busy_ok = 1'b1;
    while (cyc <= n + 20) begin
      if (ifm_rd_en) begin
        if (ifm_rd_addr !== 12'(base + rd_cnt) || wht_rd_addr !== 12'(rd_cnt) || !wht_rd_en)
          addr_ok = 1'b0;
        rd_cnt++;
      end
      if (pe_en) begin
        if (pe_cnt == 0) pe_first = cyc;
        pe_last = cyc;
        pe_cnt++;
      end
      if (pe_type !== tp) type_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (out_valid) begin
        ov_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("out_valid_cycle", ov_cyc, (n == 0) ? 1 : n + 3);
    check("read_count", rd_cnt, n);
    check("pe_en_count", pe_cnt, n);
    check("read_addresses", addr_ok, 1'b1);
    check("pe_type_stable", type_ok, 1'b1);
    check("busy_during_tile", busy_ok, 1'b1);
    if (n > 0) begin
      check("pe_en_first_cycle", pe_first, 2);
      check("pe_en_last_cycle", pe_last, n + 1);
    end
    for (int j = 0; j < LANES; j++) check($sformatf("acc_lane%0d", j), lane(j), exp_acc[j]);
    snap = acc_o;
    stable = 1'b1;
    out_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        start = 1'b1; cfg_cin = 8'd5; cfg_type = ~tp;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (out_valid !== 1'b1 || acc_o !== snap || ifm_rd_en || pe_type !== tp) stable = 1'b0;
    end
    if (hold > 0) begin
      check("backpressure_stable", stable, 1'b1);
      start = 1'b1;
      out_ready = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    check("busy_after_handshake", busy, 1'b0);
    check("out_valid_after_handshake", out_valid, 1'b0);
    @(negedge clk);
    check("idle_no_new_tile", {busy, ifm_rd_en}, 2'b00);
  endtask

  typedef struct {
    int          cin;
    int          base;
    bit          tp;
    int          md;
    logic [31:0] e0;
    logic [31:0] e1;
    int          ecyc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int ov, cyc;
    bit quiet;
    vecs[0] = '{cin: 1, base: 'h010, tp: 1'b0, md: 0, e0: 32'd3,          e1: 32'd6,          ecyc: 6};
    vecs[1] = '{cin: 4, base: 'h100, tp: 1'b1, md: 1, e0: 32'd12,         e1: 32'd12,         ecyc: 15};
    vecs[2] = '{cin: 0, base: 'h055, tp: 1'b0, md: 0, e0: 32'd0,          e1: 32'd0,          ecyc: 1};
    vecs[3] = '{cin: 1, base: 'h020, tp: 1'b1, md: 2, e0: 32'h8000_0000,  e1: 32'hFFFF_FFF1,  ecyc: 6};
    vecs[4] = '{cin: 2, base: 'hFFE, tp: 1'b0, md: 0, e0: 32'd6,          e1: 32'd12,         ecyc: 9};
    for (int j = 0; j < LANES; j++) salt[j] = '0;

    rst_n = 1'b0; start = 1'b0; cfg_cin = '0; cfg_ifm_base = '0; cfg_type = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_outputs", {ifm_rd_en, wht_rd_en, pe_en, out_valid, pe_type}, 5'b0);
    check("reset_addrs", {ifm_rd_addr, wht_rd_addr}, '0);
    check("reset_acc_zero", (acc_o == '0), 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_tile(vecs[v].cin, vecs[v].base, vecs[v].tp, vecs[v].md, 1'b0, 0, ov);
      check($sformatf("vec%0d_cycle", v), ov, vecs[v].ecyc);
      check($sformatf("vec%0d_lane0", v), lane(0), vecs[v].e0);
      check($sformatf("vec%0d_lane1", v), lane(1), vecs[v].e1);
    end

    // Backpressure with an ignored start during OUT and at the handshake.
    run_tile(2, 'h200, 1'b1, 0, 1'b0, 5, ov);

    // Reset mid-run aborts the tile.
    mode = 0;
    @(negedge clk);
    start = 1'b1; cfg_cin = 8'd8; cfg_ifm_base = 12'h300; cfg_type = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_abort_acc_nonzero", (acc_o != '0), 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_outputs", {ifm_rd_en, wht_rd_en, pe_en, out_valid, pe_type}, 5'b0);
    check("abort_addrs", {ifm_rd_addr, wht_rd_addr}, '0);
    check("abort_acc_zero", (acc_o == '0), 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || busy || pe_en) quiet = 1'b0;
    end
    check("no_output_after_abort", quiet, 1'b1);
    run_tile(1, 'h033, 1'b0, 0, 1'b0, 0, ov);
    check("fresh_lane8", lane(8), 32'd27);

    // Randomized tiles; out_ready is sometimes held high from the start.
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < LANES; j++) salt[j] = $urandom;
      run_tile($urandom_range(0, 12), $urandom_range(0, 4095), 1'($urandom_range(0, 1)),
               3, 1'($urandom_range(0, 1)), 0, ov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pe_seq_ctrl
